// File: rtl/mem_rd_arbiter_pkg.sv
// rtl/mem_rd_arbiter_pkg.sv - shared state encoding, requester ids and defaults for mem_rd_arbiter
package mem_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    localparam logic ID_IC = 1'b0;
    localparam logic ID_DC = 1'b1;

    localparam int DEFAULT_BURST_LEN = 8;

endpackage

// File: rtl/mem_rd_rr_pick.sv
// rtl/mem_rd_rr_pick.sv - combinational 2-way round-robin winner selection
//   ic_valid, dc_valid : requester valids
//   last_served        : id of the requester that completed the previous burst
//   win_id             : chosen requester id (ID_IC when nobody is valid)
module mem_rd_rr_pick
    import mem_rd_arbiter_pkg::*;
(
    input  logic ic_valid,
    input  logic dc_valid,
    input  logic last_served,
    output logic win_id
);

    always_comb begin
        win_id = ID_IC;
        if (ic_valid && dc_valid) begin
            // on a tie the requester that was not served last gets the bus
            win_id = ~last_served;
        end else if (dc_valid) begin
            win_id = ID_DC;
        end
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// rtl/mem_rd_arbiter.sv - arbitrates I-cache and D-cache line-refill reads onto one memory read port
//   clk, rst                 : clock, asynchronous active-high reset
//   ic_rd_req_* / ic_rd_rsp_*: I-cache request and response channels
//   dc_rd_req_* / dc_rd_rsp_*: D-cache request and response channels
//   to/from_mem_rd_req_*     : memory request channel
//   from/to_mem_rd_rsp_*     : memory response channel
//   busy, grant_id, proto_err: status (burst in flight, owner, sticky burst-length error)
module mem_rd_arbiter
    import mem_rd_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = DEFAULT_BURST_LEN
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ic_rd_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_rd_req_addr,
    output logic                  ic_rd_req_ready,
    output logic                  ic_rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] ic_rd_rsp_data,
    output logic                  ic_rd_rsp_last,
    input  logic                  ic_rd_rsp_ready,

    input  logic                  dc_rd_req_valid,
    input  logic [ADDR_WIDTH-1:0] dc_rd_req_addr,
    output logic                  dc_rd_req_ready,
    output logic                  dc_rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] dc_rd_rsp_data,
    output logic                  dc_rd_rsp_last,
    input  logic                  dc_rd_rsp_ready,

    output logic                  to_mem_rd_req_valid,
    output logic [ADDR_WIDTH-1:0] to_mem_rd_req_addr,
    input  logic                  from_mem_rd_req_ready,
    input  logic                  from_mem_rd_rsp_valid,
    input  logic [DATA_WIDTH-1:0] from_mem_rd_rsp_data,
    input  logic                  from_mem_rd_rsp_last,
    output logic                  to_mem_rd_rsp_ready,

    output logic                  busy,
    output logic                  grant_id,
    output logic                  proto_err
);

    localparam int                CNT_W    = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST_LEN - 1);

    state_e                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    last_served_q, last_served_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic win_id;
    logic in_req;
    logic in_rsp;
    logic gnt_rsp_ready;
    logic beat_hs;

    mem_rd_rr_pick u_rr_pick (
        .ic_valid    (ic_rd_req_valid),
        .dc_valid    (dc_rd_req_valid),
        .last_served (last_served_q),
        .win_id      (win_id)
    );

    assign in_req        = (state_q == ST_REQ);
    assign in_rsp        = (state_q == ST_RSP);
    assign gnt_rsp_ready = (grant_q == ID_DC) ? dc_rd_rsp_ready : ic_rd_rsp_ready;
    assign beat_hs       = in_rsp && from_mem_rd_rsp_valid && gnt_rsp_ready;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_served_d = last_served_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        case (state_q)
            ST_IDLE: begin
                if (ic_rd_req_valid || dc_rd_req_valid) begin
                    grant_d = win_id;
                    addr_d  = (win_id == ID_DC) ? dc_rd_req_addr : ic_rd_req_addr;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (from_mem_rd_req_ready) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (beat_hs) begin
                    // saturate so an overlong burst cannot wrap back to a legal count
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (from_mem_rd_rsp_last) begin
                        state_d       = ST_IDLE;
                        cnt_d         = '0;
                        last_served_d = grant_q;
                        if (cnt_q != CNT_LAST) begin
                            err_d = 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        // this beat makes the count reach BURST_LEN with no last
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= ID_IC;
            last_served_q <= ID_DC;
            addr_q        <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_served_q <= last_served_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
        end
    end

    assign to_mem_rd_req_valid = in_req;
    assign to_mem_rd_req_addr  = in_req ? addr_q : '0;
    assign to_mem_rd_rsp_ready = in_rsp && gnt_rsp_ready;

    assign ic_rd_req_ready = in_req && (grant_q == ID_IC) && from_mem_rd_req_ready;
    assign dc_rd_req_ready = in_req && (grant_q == ID_DC) && from_mem_rd_req_ready;

    assign ic_rd_rsp_valid = in_rsp && (grant_q == ID_IC) && from_mem_rd_rsp_valid;
    assign dc_rd_rsp_valid = in_rsp && (grant_q == ID_DC) && from_mem_rd_rsp_valid;
    assign ic_rd_rsp_last  = in_rsp && (grant_q == ID_IC) && from_mem_rd_rsp_last;
    assign dc_rd_rsp_last  = in_rsp && (grant_q == ID_DC) && from_mem_rd_rsp_last;

    // data is broadcast; only the pass-through needs gating to stay quiet during reset
    assign ic_rd_rsp_data = rst ? '0 : from_mem_rd_rsp_data;
    assign dc_rd_rsp_data = rst ? '0 : from_mem_rd_rsp_data;

    assign busy      = in_req || in_rsp;
    assign grant_id  = grant_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb/tb_mem_rd_arbiter.sv - self-checking bench for mem_rd_arbiter
module tb_mem_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ic_rd_req_valid, ic_rd_req_ready, ic_rd_rsp_valid, ic_rd_rsp_last, ic_rd_rsp_ready;
    logic [AW-1:0] ic_rd_req_addr;
    logic [DW-1:0] ic_rd_rsp_data;
    logic          dc_rd_req_valid, dc_rd_req_ready, dc_rd_rsp_valid, dc_rd_rsp_last, dc_rd_rsp_ready;
    logic [AW-1:0] dc_rd_req_addr;
    logic [DW-1:0] dc_rd_rsp_data;
    logic          to_mem_rd_req_valid, from_mem_rd_req_ready;
    logic [AW-1:0] to_mem_rd_req_addr;
    logic          from_mem_rd_rsp_valid, from_mem_rd_rsp_last, to_mem_rd_rsp_ready;
    logic [DW-1:0] from_mem_rd_rsp_data;
    logic          busy, grant_id, proto_err;

    always #5 clk = ~clk;

    mem_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .ic_rd_req_valid       (ic_rd_req_valid),
        .ic_rd_req_addr        (ic_rd_req_addr),
        .ic_rd_req_ready       (ic_rd_req_ready),
        .ic_rd_rsp_valid       (ic_rd_rsp_valid),
        .ic_rd_rsp_data        (ic_rd_rsp_data),
        .ic_rd_rsp_last        (ic_rd_rsp_last),
        .ic_rd_rsp_ready       (ic_rd_rsp_ready),
        .dc_rd_req_valid       (dc_rd_req_valid),
        .dc_rd_req_addr        (dc_rd_req_addr),
        .dc_rd_req_ready       (dc_rd_req_ready),
        .dc_rd_rsp_valid       (dc_rd_rsp_valid),
        .dc_rd_rsp_data        (dc_rd_rsp_data),
        .dc_rd_rsp_last        (dc_rd_rsp_last),
        .dc_rd_rsp_ready       (dc_rd_rsp_ready),
        .to_mem_rd_req_valid   (to_mem_rd_req_valid),
        .to_mem_rd_req_addr    (to_mem_rd_req_addr),
        .from_mem_rd_req_ready (from_mem_rd_req_ready),
        .from_mem_rd_rsp_valid (from_mem_rd_rsp_valid),
        .from_mem_rd_rsp_data  (from_mem_rd_rsp_data),
        .from_mem_rd_rsp_last  (from_mem_rd_rsp_last),
        .to_mem_rd_rsp_ready   (to_mem_rd_rsp_ready),
        .busy                  (busy),
        .grant_id              (grant_id),
        .proto_err             (proto_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: sticky error expectation and who finished the previous burst
    bit exp_err  = 1'b0;
    bit exp_last = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ic_rd_req_valid       = 1'b0;
        ic_rd_req_addr        = '0;
        ic_rd_rsp_ready       = 1'b0;
        dc_rd_req_valid       = 1'b0;
        dc_rd_req_addr        = '0;
        dc_rd_rsp_ready       = 1'b0;
        from_mem_rd_req_ready = 1'b0;
        from_mem_rd_rsp_valid = 1'b0;
        from_mem_rd_rsp_data  = '0;
        from_mem_rd_rsp_last  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'(|{ic_rd_req_ready, ic_rd_rsp_valid, ic_rd_rsp_data, ic_rd_rsp_last,
                       dc_rd_req_ready, dc_rd_rsp_valid, dc_rd_rsp_data, dc_rd_rsp_last,
                       to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready,
                       busy, grant_id, proto_err}), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst                   = 1'b1;
        ic_rd_req_valid       = 1'b1;
        ic_rd_req_addr        = '1;
        ic_rd_rsp_ready       = 1'b1;
        dc_rd_req_valid       = 1'b1;
        dc_rd_req_addr        = '1;
        dc_rd_rsp_ready       = 1'b1;
        from_mem_rd_req_ready = 1'b1;
        from_mem_rd_rsp_valid = 1'b1;
        from_mem_rd_rsp_data  = '1;
        from_mem_rd_rsp_last  = 1'b1;
        #1;
        chk_all_zero("reset_outputs_zero");
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        exp_err  = 1'b0;
        exp_last = 1'b1;
        @(posedge clk);
    endtask

    // One arbitration + burst, entered just after the edge that left the arbiter idle.
    // rdy_mode: 0 always ready, 1 toggle 1,0,..., 2 random.
    task automatic run_txn(input bit want_ic, input bit want_dc,
                           input logic [AW-1:0] ia, input logic [AW-1:0] da,
                           input int nbeats, input int rdy_mode,
                           input int raise_dc_beat, input int abort_beat);
        bit            who, v, r, lst, tog, done;
        logic [AW-1:0] addr;
        logic [DW-1:0] d;
        int            b, tries, budget;

        @(negedge clk);
        if (want_ic && !ic_rd_req_valid) begin ic_rd_req_valid = 1'b1; ic_rd_req_addr = ia; end
        if (want_dc && !dc_rd_req_valid) begin dc_rd_req_valid = 1'b1; dc_rd_req_addr = da; end
        from_mem_rd_req_ready = 1'($urandom_range(0, 1));
        from_mem_rd_rsp_valid = 1'b0;
        from_mem_rd_rsp_last  = 1'b0;
        if (ic_rd_req_valid && dc_rd_req_valid) who = (exp_last == 1'b1) ? 1'b0 : 1'b1;
        else                                    who = dc_rd_req_valid;
        addr = who ? dc_rd_req_addr : ic_rd_req_addr;
        #1;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_mem_req_valid", 64'(to_mem_rd_req_valid), 64'd0);
        chk("idle_mem_req_addr", 64'(to_mem_rd_req_addr), 64'd0);
        chk("idle_req_ready", 64'({ic_rd_req_ready, dc_rd_req_ready}), 64'd0);
        chk("idle_mem_rsp_ready", 64'(to_mem_rd_rsp_ready), 64'd0);
        chk("idle_proto_err", 64'(proto_err), 64'(exp_err));
        @(posedge clk);

        tries = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            from_mem_rd_req_ready = (tries >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            chk("req_mem_valid", 64'(to_mem_rd_req_valid), 64'd1);
            chk("req_mem_addr", 64'(to_mem_rd_req_addr), 64'(addr));
            chk("req_grant_id", 64'(grant_id), 64'(who));
            chk("req_busy", 64'(busy), 64'd1);
            chk("req_ic_ready", 64'(ic_rd_req_ready), 64'(!who && from_mem_rd_req_ready));
            chk("req_dc_ready", 64'(dc_rd_req_ready), 64'(who && from_mem_rd_req_ready));
            done = from_mem_rd_req_ready;
            tries++;
            @(posedge clk);
        end

        b      = 0;
        budget = 0;
        tog    = 1'b1;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (budget == 0) begin
                if (who) dc_rd_req_valid = 1'b0;
                else     ic_rd_req_valid = 1'b0;
                from_mem_rd_req_ready = 1'b0;
            end
            if (b == raise_dc_beat && !dc_rd_req_valid) begin
                dc_rd_req_valid = 1'b1;
                dc_rd_req_addr  = da;
            end
            v   = ($urandom_range(0, 3) != 0) || (b == abort_beat);
            d   = $urandom;
            lst = (b == nbeats - 1);
            case (rdy_mode)
                0:       r = 1'b1;
                1:       r = tog;
                default: r = 1'($urandom_range(0, 1));
            endcase
            tog = !tog;
            from_mem_rd_rsp_valid = v;
            from_mem_rd_rsp_data  = d | 32'h1;
            from_mem_rd_rsp_last  = lst;
            if (who) begin dc_rd_rsp_ready = r; ic_rd_rsp_ready = 1'($urandom_range(0, 1)); end
            else     begin ic_rd_rsp_ready = r; dc_rd_rsp_ready = 1'($urandom_range(0, 1)); end
            if (b == abort_beat) begin
                rst = 1'b1;
                #1;
                chk_all_zero("abort_outputs_zero");
                @(negedge clk);
                rst = 1'b0;
                clear_inputs();
                exp_err  = 1'b0;
                exp_last = 1'b1;
                @(posedge clk);
                return;
            end
            #1;
            chk("rsp_mem_ready", 64'(to_mem_rd_rsp_ready), 64'(r));
            chk("rsp_gnt_valid", 64'(who ? dc_rd_rsp_valid : ic_rd_rsp_valid), 64'(v));
            chk("rsp_other_valid", 64'(who ? ic_rd_rsp_valid : dc_rd_rsp_valid), 64'd0);
            chk("rsp_gnt_last", 64'(who ? dc_rd_rsp_last : ic_rd_rsp_last), 64'(lst));
            chk("rsp_req_ready", 64'({ic_rd_req_ready, dc_rd_req_ready}), 64'd0);
            chk("rsp_busy", 64'(busy), 64'd1);
            chk("rsp_mem_req_valid", 64'(to_mem_rd_req_valid), 64'd0);
            chk("rsp_proto_err", 64'(proto_err), 64'(exp_err));
            if (v) begin
                chk("rsp_ic_data", 64'(ic_rd_rsp_data), 64'(d | 32'h1));
                chk("rsp_dc_data", 64'(dc_rd_rsp_data), 64'(d | 32'h1));
            end
            budget++;
            if (budget > 200) begin
                chk("rsp_cycle_budget", 64'(budget), 64'd200);
                done = 1'b1;
            end
            @(posedge clk);
            if (v && r) begin
                if ((lst && b != BL - 1) || (!lst && b == BL - 1)) exp_err = 1'b1;
                b++;
                if (lst) begin
                    done     = 1'b1;
                    exp_last = who;
                end
            end
        end
        chk("beat_count", 64'(b), 64'(nbeats));
    endtask

    initial begin
        bit wi, wd;
        clear_inputs();
        repeat (2) @(posedge clk);
        do_reset();

        // single I-cache line refill
        run_txn(1'b1, 1'b0, 32'h0000_1000, '0, BL, 0, -1, -1);

        // simultaneous requests right after reset: IC then DC; later tie after IC goes to DC
        do_reset();
        run_txn(1'b1, 1'b1, 32'h0000_0100, 32'h8000_0200, BL, 2, -1, -1);
        run_txn(1'b0, 1'b0, '0, '0, BL, 2, -1, -1);
        run_txn(1'b1, 1'b0, 32'h0000_0140, '0, BL, 0, -1, -1);
        run_txn(1'b1, 1'b1, 32'h0000_0180, 32'h8000_0240, BL, 0, -1, -1);
        run_txn(1'b0, 1'b0, '0, '0, BL, 0, -1, -1);

        // D-cache back-pressure toggling every cycle
        run_txn(1'b0, 1'b1, '0, 32'h8000_0300, BL, 1, -1, -1);

        // D-cache request raised while the I-cache burst is in flight
        run_txn(1'b1, 1'b0, 32'h0000_2000, 32'h8000_0400, BL, 0, 2, -1);
        run_txn(1'b0, 1'b0, '0, '0, BL, 0, -1, -1);

        // randomized traffic
        for (int i = 0; i < 12; i++) begin
            wi = 1'($urandom_range(0, 1));
            wd = 1'($urandom_range(0, 1));
            if (!wi && !wd) wi = 1'b1;
            run_txn(wi, wd, $urandom, $urandom, BL, 2, -1, -1);
        end
        if (ic_rd_req_valid || dc_rd_req_valid) run_txn(1'b0, 1'b0, '0, '0, BL, 2, -1, -1);

        // short burst (last on beat 5) sets the sticky error, which survives the next burst
        run_txn(1'b1, 1'b0, 32'h0000_3000, '0, 6, 0, -1, -1);
        run_txn(1'b0, 1'b1, '0, 32'h8000_0500, BL, 0, -1, -1);

        // overlong burst
        do_reset();
        run_txn(1'b1, 1'b0, 32'h0000_3100, '0, BL + 1, 0, -1, -1);

        // reset during beat 3, then a normal D-cache request
        do_reset();
        run_txn(1'b1, 1'b0, 32'h0000_4000, '0, BL, 0, -1, 3);
        run_txn(1'b0, 1'b1, '0, 32'h8000_0600, BL, 2, -1, -1);

        @(negedge clk);
        #1;
        chk("final_busy", 64'(busy), 64'd0);
        chk("final_proto_err", 64'(proto_err), 64'(exp_err));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_rd_arbiter.md
MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, beat width.
REQ-003 SHALL have parameter BURST_LEN, default 8, beats per line refill.
REQ-004 SHALL have one clock and one reset: clk, input, 1, sole clock, rising edge; rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have the I-cache request ports: ic_rd_req_valid in 1; ic_rd_req_addr in ADDR_WIDTH; ic_rd_req_ready out 1.
REQ-006 SHALL have the I-cache response ports: ic_rd_rsp_valid out 1; ic_rd_rsp_data out DATA_WIDTH; ic_rd_rsp_last out 1; ic_rd_rsp_ready in 1.
REQ-007 SHALL have the D-cache request ports: dc_rd_req_valid in 1; dc_rd_req_addr in ADDR_WIDTH; dc_rd_req_ready out 1.
REQ-008 SHALL have the D-cache response ports: dc_rd_rsp_valid out 1; dc_rd_rsp_data out DATA_WIDTH; dc_rd_rsp_last out 1; dc_rd_rsp_ready in 1.
REQ-009 SHALL have the memory request ports: to_mem_rd_req_valid out 1; to_mem_rd_req_addr out ADDR_WIDTH; from_mem_rd_req_ready in 1.
REQ-010 SHALL have the memory response ports: from_mem_rd_rsp_valid in 1; from_mem_rd_rsp_data in DATA_WIDTH; from_mem_rd_rsp_last in 1; to_mem_rd_rsp_ready out 1.
REQ-011 SHALL have the status ports: busy out 1, burst in flight; grant_id out 1, 0=I-cache, 1=D-cache; proto_err out 1, sticky burst-length error.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, REQ, RSP.
REQ-013 IDLE: if any requester valid, SHALL pick a winner, latch its id into grant_id and its address into an address register, and go to REQ next cycle; else SHALL stay in IDLE.
REQ-014 Arbitration SHALL be 2-way round-robin: if both are valid, the requester not served last wins; if only one is valid, it wins.
REQ-015 REQ: to_mem_rd_req_valid=1 and to_mem_rd_req_addr=latched address; the granted req_ready SHALL equal from_mem_rd_req_ready combinationally; on that handshake the FSM SHALL go to RSP.
REQ-016 RSP: the granted rsp_valid/last SHALL equal from_mem_rd_rsp_valid/last; to_mem_rd_rsp_ready SHALL equal the granted rsp_ready.
REQ-017 rsp_data SHALL be forwarded to both requesters; it is qualified only by the granted rsp_valid.
REQ-018 The non-granted requester SHALL see req_ready=0 and rsp_valid=0 at all times.
REQ-019 Outside REQ, to_mem_rd_req_valid SHALL be 0 and to_mem_rd_req_addr SHALL be 0. Outside RSP, to_mem_rd_rsp_ready SHALL be 0.
REQ-020 A beat counter of width clog2(BURST_LEN)+1 SHALL increment on each RSP beat handshake (valid&&ready) and clear when leaving RSP.
REQ-021 A handshake with last=1 SHALL move the FSM to IDLE and record grant_id as last-served; the earliest new request can be issued two cycles later.
REQ-022 proto_err SHALL set if last arrives with counter != BURST_LEN-1, or if the counter reaches BURST_LEN without last; it SHALL hold until reset.
REQ-023 Beats arriving with rsp_ready=0 SHALL stall without counting.
REQ-024 busy SHALL be 1 in REQ and RSP, and 0 in IDLE.
REQ-025 A requester that raises valid while the other is in flight SHALL wait; its valid and addr SHALL remain stable until its req_ready handshake.

Reset
REQ-026 rst SHALL asynchronously force: state=IDLE, grant_id=0, last-served=D-cache (I-cache wins the first tie), address register=0, counter=0, proto_err=0.
REQ-027 While in reset, every output SHALL be 0.
REQ-028 Reset mid-burst SHALL abandon the burst without draining; after release the arbiter SHALL accept new requests from IDLE.

Structure
REQ-029 A shared package SHALL hold the state encoding, the requester id constants (IC=0, DC=1), and default BURST_LEN.
REQ-030 The round-robin pick SHALL be a sub-module mem_rd_rr_pick; it is combinational and takes two valids plus last-served, and returns the winner id.

Verification
REQ-031 Bench: only I-cache requests addr 0x0000_1000, 8 beats 0..7 -> mem sees addr 0x1000 one cycle after valid; I-cache gets 8 beats, last on beat 7; proto_err=0.
REQ-032 Bench: both valid from the first cycle after reset (IC 0x100, DC 0x8000_0200) -> IC served first, then DC; the next simultaneous pair is DC first.
REQ-033 Bench: D-cache rsp_ready toggles 1,0 every cycle -> to_mem_rd_rsp_ready mirrors it; 8 beats counted; no beat lost or duplicated.
REQ-034 Bench: memory asserts last on beat 5 -> proto_err=1 from the next cycle and sticky; the FSM returns to IDLE.
REQ-035 Bench: rst asserted during beat 3 of an IC burst -> all outputs 0 immediately; after release a DC request is granted normally.
REQ-036 Bench: DC valid raised during an IC RSP -> dc_rd_req_ready stays 0 until IC last; DC is issued two cycles after IC last.
